// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: FSM states, error codes, command bytes, parity.
// Used by both the host transmitter and the receiver path.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        REQ,
        BITS,
        STOP,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_NO_CLK   = 2'd1;
    localparam logic [1:0] ERR_FRAME_TO = 2'd2;
    localparam logic [1:0] ERR_NO_ACK   = 2'd3;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake bundle between a requester and the PS/2 host transmitter.
// master: tx_data/tx_valid out; slave: tx_ready/busy/done/err/err_code out.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, err, err_code
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, err, err_code
    );

endinterface

// File: rtl/ps2_line_sync.sv
// PS/2 pin conditioning: 2-FF synchroniser, glitch filter, kclk falling edge.
// Ports: clk, rst, kclk/kdata (pins) -> kclk_f/kdata_f (filtered), kclk_fall (pulse).
module ps2_line_sync #(
    parameter int FILT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic kclk,
    input  logic kdata,
    output logic kclk_f,
    output logic kdata_f,
    output logic kclk_fall
);

    localparam int CW = $clog2(FILT_CYCLES) + 1;

    // bit 0 = clock line, bit 1 = data line
    logic [1:0]         s1, s2, filt;
    logic [1:0][CW-1:0] cnt;
    logic [1:0]         flip;

    // A level is accepted after FILT_CYCLES consecutive differing samples.
    always_comb begin
        flip = '0;
        for (int i = 0; i < 2; i++) begin
            flip[i] = (s2[i] != filt[i]) && (cnt[i] == CW'(FILT_CYCLES - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= '1;
            s2        <= '1;
            filt      <= '1;
            cnt       <= '0;
            kclk_fall <= 1'b0;
        end else begin
            s1 <= {kdata, kclk};
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    cnt[i]  <= '0;
                    filt[i] <= s2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            kclk_fall <= flip[0] & filt[0];
        end
    end

    assign kclk_f  = filt[0];
    assign kdata_f = filt[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits, odd parity, ack.
// Ports: clk, rst, tx (slave handshake), kclk/kdata pins, kclk_oe/kdata_oe pull-downs.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int START_TO_MS = 15,
    parameter int FRAME_TO_MS = 2,
    parameter int FILT_CYCLES = 8
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  tx,
    input  logic          kclk,
    input  logic          kdata,
    output logic          kclk_oe,
    output logic          kdata_oe
);

    localparam int INH  = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int STO  = CLK_FREQ_HZ / 1000 * START_TO_MS;
    localparam int FTO  = CLK_FREQ_HZ / 1000 * FRAME_TO_MS;
    localparam int TM1  = (INH > STO) ? INH : STO;
    localparam int TMAX = (TM1 > FTO) ? TM1 : FTO;
    localparam int TW   = $clog2(TMAX + 1);

    ps2_state_t state, nxt;
    logic [TW-1:0] tmr;
    logic          tmr_clr;
    logic [8:0]    shreg;
    logic [3:0]    bitcnt;
    logic [1:0]    ecode;
    logic [1:0]    err_code_q;
    logic          frame_to;
    logic          kclk_f, kdata_f, fall;

    ps2_line_sync #(.FILT_CYCLES(FILT_CYCLES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .kclk      (kclk),
        .kdata     (kdata),
        .kclk_f    (kclk_f),
        .kdata_f   (kdata_f),
        .kclk_fall (fall)
    );

    // One timer serves inhibit, start wait and frame; they never overlap.
    assign frame_to = (tmr >= TW'(FTO - 1));

    always_comb begin
        nxt      = state;
        tmr_clr  = 1'b0;
        kclk_oe  = 1'b0;
        kdata_oe = 1'b0;
        ecode    = ERR_FRAME_TO;
        unique case (state)
            IDLE: begin
                if (tx.tx_valid) begin
                    nxt     = INHIBIT;
                    tmr_clr = 1'b1;
                end
            end
            INHIBIT: begin
                kclk_oe = 1'b1;
                if (tmr >= TW'(INH - 1)) begin
                    kdata_oe = 1'b1;
                    nxt      = REQ;
                    tmr_clr  = 1'b1;
                end
            end
            REQ: begin
                kdata_oe = 1'b1;
                ecode    = ERR_NO_CLK;
                if (tmr >= TW'(STO - 1)) begin
                    nxt = ERR;
                end else if (fall) begin
                    nxt     = BITS;
                    tmr_clr = 1'b1;
                end
            end
            BITS: begin
                kdata_oe = ~shreg[bitcnt];
                if (frame_to)                   nxt = ERR;
                else if (fall && bitcnt == 4'd8) nxt = STOP;
            end
            STOP: begin
                if (frame_to)  nxt = ERR;
                else if (fall) nxt = ACK;
            end
            ACK: begin
                if (frame_to) begin
                    nxt = ERR;
                end else if (fall) begin
                    if (kdata_f) begin
                        nxt   = ERR;
                        ecode = ERR_NO_ACK;
                    end else begin
                        nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (frame_to)               nxt = ERR;
                else if (kclk_f && kdata_f) nxt = DONE;
            end
            DONE:    nxt = IDLE;
            ERR:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmr        <= '0;
            shreg      <= '0;
            bitcnt     <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state <= nxt;
            if (tmr_clr)                 tmr <= '0;
            else if (tmr != TW'(TMAX))   tmr <= tmr + 1'b1;
            if (state == IDLE && tx.tx_valid) begin
                shreg      <= {odd_parity(tx.tx_data), tx.tx_data};
                err_code_q <= ERR_NONE;
            end
            if (state == REQ && nxt == BITS) begin
                bitcnt <= '0;
            end else if (state == BITS && nxt == BITS && fall) begin
                bitcnt <= bitcnt + 1'b1;
            end
            if (nxt == ERR && state != ERR) err_code_q <= ecode;
        end
    end

    assign tx.tx_ready = (state == IDLE);
    assign tx.busy     = (state != IDLE);
    assign tx.done     = (state == DONE);
    assign tx.err      = (state == ERR);
    assign tx.err_code = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a PS/2 device model.
// Table of full transfers plus directed timeout, back-to-back and reset sequences.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic kclk, kdata, kclk_oe, kdata_oe;
    logic bclk = 1'b1;
    logic bdat = 1'b1;

    ps2_host_tx_if tx();

    ps2_host_tx #(
        .CLK_FREQ_HZ (1_000_000),
        .INHIBIT_US  (100),
        .START_TO_MS (15),
        .FRAME_TO_MS (2),
        .FILT_CYCLES (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx       (tx),
        .kclk     (kclk),
        .kdata    (kdata),
        .kclk_oe  (kclk_oe),
        .kdata_oe (kdata_oe)
    );

    // open-drain lines with pull-ups
    assign kclk  = bclk & ~kclk_oe;
    assign kdata = bdat & ~kdata_oe;

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int cyc = 0, n_done = 0, n_err = 0, done_cyc = 0, acc_cyc = 0;
    logic busy_at, ready_at, busy_nx, ready_nx;
    bit pend = 0;

    always @(negedge clk) begin
        cyc++;
        if (pend) begin
            busy_nx  = tx.busy;
            ready_nx = tx.tx_ready;
            pend     = 0;
        end
        if (tx.tx_valid === 1'b1 && tx.tx_ready === 1'b1) acc_cyc = cyc;
        if (tx.done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        if (tx.err === 1'b1) n_err++;
        if (tx.done === 1'b1 || tx.err === 1'b1) begin
            busy_at  = tx.busy;
            ready_at = tx.tx_ready;
            pend     = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx.tx_data  = d;
        tx.tx_valid = 1'b1;
        @(negedge clk);
        tx.tx_valid = 1'b0;
        tx.tx_data  = ~d;
    endtask

    // got[0]=start, got[1..8]=d0..d7, got[9]=parity, got[10]=stop
    logic [10:0] got;

    task automatic device(input int npulses, input bit ack, input bit glitch);
        int n;
        got = '0;
        n = 0;
        while (kclk_oe !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            tmo("dev_inhibit");
            return;
        end
        n = 0;
        while (!(kclk_oe === 1'b0 && kdata_oe === 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            tmo("dev_req");
            return;
        end
        got[0] = kdata;
        repeat (30) @(negedge clk);
        for (int p = 1; p <= npulses; p++) begin
            bclk = 1'b0;
            repeat (40) @(negedge clk);
            bclk = 1'b1;
            if (p <= 10) got[p] = kdata;
            if (p == 10 && ack) bdat = 1'b0;
            repeat (5) @(negedge clk);
            if (p == 12) bdat = 1'b1;
            repeat (5) @(negedge clk);
            if (glitch && p <= 9) begin
                bclk = 1'b0;
                @(negedge clk);
                bclk = 1'b1;
                repeat (29) @(negedge clk);
            end else begin
                repeat (30) @(negedge clk);
            end
        end
        bdat = 1'b1;
    endtask

    task automatic wait_end(input int base, input string name);
        int n = 0;
        while (n_done + n_err == base && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) tmo(name);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          ack;
        bit          glitch;
        logic [10:0] frame;
        int          dn;
        int          er;
        logic [1:0]  code;
    } vec_t;

    vec_t v[5];

    initial begin
        int base, d0, e0, n, m, inh, inhd, lowv;
        logic [10:0] g1;

        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'h00;

        v[0] = '{8'hF4, 1'b1, 1'b0, 11'h5E8, 1, 0, 2'd0};
        v[1] = '{8'hF3, 1'b1, 1'b0, 11'h7E6, 1, 0, 2'd0};
        v[2] = '{8'hF4, 1'b0, 1'b0, 11'h5E8, 0, 1, 2'd3};
        v[3] = '{8'hF4, 1'b1, 1'b1, 11'h5E8, 1, 0, 2'd0};
        v[4] = '{8'h00, 1'b1, 1'b1, 11'h600, 1, 0, 2'd0};

        repeat (3) @(negedge clk);
        chk("rst_ready", tx.tx_ready, 1);
        chk("rst_busy", tx.busy, 0);
        chk("rst_done", tx.done, 0);
        chk("rst_err", tx.err, 0);
        chk("rst_code", tx.err_code, 0);
        chk("rst_oe", {kclk_oe, kdata_oe}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            base = n_done + n_err;
            d0   = n_done;
            e0   = n_err;
            send(v[i].data);
            device(12, v[i].ack, v[i].glitch);
            wait_end(base, $sformatf("v%0d_end", i));
            chk($sformatf("v%0d_frame", i), got, v[i].frame);
            chk($sformatf("v%0d_done", i), n_done - d0, v[i].dn);
            chk($sformatf("v%0d_errs", i), n_err - e0, v[i].er);
            chk($sformatf("v%0d_code", i), tx.err_code, v[i].code);
            chk($sformatf("v%0d_busy_pulse", i), busy_at, 1);
            chk($sformatf("v%0d_ready_pulse", i), ready_at, 0);
            chk($sformatf("v%0d_ready_next", i), ready_nx, 1);
            chk($sformatf("v%0d_busy_next", i), busy_nx, 0);
            chk($sformatf("v%0d_oe_idle", i), {kclk_oe, kdata_oe}, 0);
            repeat (20) @(negedge clk);
        end

        // back-to-back: valid held, data changed while busy
        base = n_done + n_err;
        d0   = n_done;
        @(negedge clk);
        tx.tx_data  = 8'h00;
        tx.tx_valid = 1'b1;
        @(negedge clk);
        tx.tx_data = 8'hFF;
        device(12, 1'b1, 1'b0);
        wait_end(base, "b2b_first_end");
        g1 = got;
        tx.tx_valid = 1'b0;
        chk("b2b_first_frame", g1, 11'h600);
        chk("b2b_accept_gap", acc_cyc - done_cyc, 1);
        device(12, 1'b1, 1'b0);
        wait_end(base + 1, "b2b_second_end");
        chk("b2b_second_frame", got, 11'h7FE);
        chk("b2b_done_count", n_done - d0, 2);
        repeat (20) @(negedge clk);

        // device never clocks
        send(CMD_ENABLE);
        n = 0;
        inh = 0;
        inhd = 0;
        while (kclk_oe === 1'b1 && n < 1000) begin
            inh++;
            if (kdata_oe === 1'b1) inhd++;
            @(negedge clk);
            n++;
        end
        chk("noclk_inhibit_len", inh, 100);
        chk("noclk_inhibit_data", inhd, 1);
        chk("noclk_req_data", kdata_oe, 1);
        m = 0;
        lowv = 0;
        while (tx.err !== 1'b1 && m < 20000) begin
            if (kdata_oe !== 1'b1 || kclk_oe !== 1'b0) lowv++;
            @(negedge clk);
            m++;
        end
        chk("noclk_err_time", m, 15000);
        chk("noclk_req_held", lowv, 0);
        chk("noclk_code", tx.err_code, 1);
        @(negedge clk);
        chk("noclk_oe", {kclk_oe, kdata_oe}, 0);
        repeat (20) @(negedge clk);

        // device stops after bit 4
        send(CMD_ENABLE);
        device(5, 1'b1, 1'b0);
        m = 0;
        while (tx.err !== 1'b1 && m < 3000) begin
            @(negedge clk);
            m++;
        end
        chk_rng("frame_to_time", 400 + m, 2000, 2030);
        chk("frame_to_code", tx.err_code, 2);
        @(negedge clk);
        chk("frame_to_oe", {kclk_oe, kdata_oe}, 0);
        repeat (20) @(negedge clk);

        // async reset in the middle of the data bits
        send(CMD_ENABLE);
        device(4, 1'b1, 1'b0);
        chk("rst_mid_pre_kdata", kdata_oe, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_oe", {kclk_oe, kdata_oe}, 0);
        chk("rst_mid_busy", tx.busy, 0);
        chk("rst_mid_ready", tx.tx_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        base = n_done + n_err;
        d0   = n_done;
        send(CMD_SET_RATE);
        device(12, 1'b1, 1'b0);
        wait_end(base, "rst_after_end");
        chk("rst_after_frame", got, 11'h7E6);
        chk("rst_after_done", n_done - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
